trace_sink: RTL
===============

TRACE_SINK -- requirements
Module: trace_sink

Interface
REQ-001 SHALL have parameter ADDR_W, default 36: byte-address width of the AXI write master.
REQ-002 SHALL have parameter SLOT_BYTES, default 256: bytes per ring slot, equal to one 8-beat, 256-bit burst.
REQ-003 SHALL provide ports: aclk in 1: sole clock; areset in 1: asynchronous, active-high reset.
REQ-004 SHALL provide s_axis_trace_tvalid in 1 / s_axis_trace_tready out 1: AXIS handshake.
REQ-005 SHALL provide s_axis_trace_tdata in 512, s_axis_trace_tkeep in 64, s_axis_trace_tlast in 1: trace payload, byte enables, record end.
REQ-006 SHALL provide cfg_enable in 1, cfg_base in ADDR_W (256B-aligned), cfg_size in ADDR_W (nonzero multiple of 256): ring control.
REQ-007 SHALL provide write-only master m_axi_mem_aw*: awaddr ADDR_W, awlen 8, awsize 3, awburst 2, awcache 4, awlock 1, awprot 3, awqos 4, awvalid out / awready in.
REQ-008 SHALL provide m_axi_mem_wdata out 256, wstrb out 32, wlast out 1, wvalid out 1, wready in 1.
REQ-009 SHALL provide m_axi_mem_bresp in 2, bvalid in 1, bready out 1.
REQ-010 SHALL provide wr_ptr out ADDR_W: byte offset of next slot; wrap_cnt out 32; bus_err out 1 (sticky); busy out 1.

Function
REQ-011 SHALL stage up to 4 AXIS beats (one slot) in an internal buffer; FSM states IDLE, FILL, AW, W, B.
REQ-012 IDLE->FILL when cfg_enable=1; tready=1 only in FILL.
REQ-013 FILL->AW on the cycle after the 4th accepted beat or after an accepted beat with tlast=1, whichever is first.
REQ-014 AW: awvalid=1, awaddr=cfg_base+wr_ptr, awlen=7, awsize=5, awburst=INCR, awcache=4'b0011, awlock/awprot/awqos=0; ->W on awready.
REQ-015 W: exactly 8 beats; each staged 512-bit beat emits lower 256 bits then upper 256 bits, wstrb=tkeep[31:0] then tkeep[63:32]; unfilled beats wdata=0, wstrb=0; wlast on beat 8; ->B after last wready.
REQ-016 B: bready=1; on bvalid, bus_err|=(bresp!=OKAY); wr_ptr+=256, or 0 with wrap_cnt+=1 when wr_ptr+256==cfg_size; ->FILL if cfg_enable else IDLE.
REQ-017 Every burst occupies a full slot regardless of fill level; records never straddle slots.
REQ-018 Deasserting cfg_enable during FILL with ≥1 staged beat SHALL flush as a partial burst; with 0 staged beats, ->IDLE next cycle.
REQ-019 wr_ptr, wrap_cnt SHALL change only in B on bvalid; wrap_cnt wraps modulo 2^32.
REQ-020 busy=1 in AW, W, B.
REQ-021 AXI valids SHALL hold until handshake and payload SHALL stay stable while valid.

Reset
REQ-022 areset SHALL clear FSM to IDLE, all valids/readies to 0, wr_ptr=0, wrap_cnt=0, bus_err=0, buffer count=0.
REQ-023 Reset mid-burst SHALL abandon the transaction; the shell resets the interconnect alongside.

Configuration
REQ-024 Macro TRACE_SINK_DROP_EN: when defined, tready=1 whenever cfg_enable=1 and state!=IDLE; beats arriving outside FILL are discarded and counted in extra output drop_cnt (32 bits, reset 0, saturating).
REQ-025 Without TRACE_SINK_DROP_EN, the sink SHALL backpressure (REQ-012); drop_cnt SHALL not exist.

Structure
REQ-026 Package trace_sink_pkg SHALL hold the FSM state enum, SLOT_BYTES, AXI constants (INCR, OKAY, AWSIZE_32B, AWCACHE_DEFAULT).
REQ-027 One sub-module trace_sink_stage (4x512 buffer, fill count, 512->256 beat/strobe split) is natural.

Verification
REQ-028 4 full-keep beats, cfg_base=0x1_0000_0000, cfg_size=0x400 -> one AW @0x1_0000_0000 awlen=7, 8 W beats all wstrb=0xFFFFFFFF, wr_ptr=0x100.
REQ-029 1 beat with tlast, tkeep=0x0000_0000_FFFF_FFFF -> 8 W beats, wstrb FFFFFFFF,0, then 6×0; wlast on beat 8.
REQ-030 5 full slots, cfg_size=0x400 -> 5th awaddr=cfg_base+0, wrap_cnt=1, wr_ptr=0x100.
REQ-031 bresp=SLVERR on burst 2 -> bus_err=1 and stays 1; wr_ptr still advances.
REQ-032 awready/wready held low 20 cycles -> awaddr/wdata stable, tready=0 (drop_cnt counts all offered beats with TRACE_SINK_DROP_EN).
REQ-033 areset asserted in W after beat 3 -> all outputs reset values next edge; after release plus cfg_enable, next awaddr=cfg_base.

Source files
------------

// File: rtl/trace_sink_pkg.sv
// Shared types and constants for the trace_sink ring-buffer writer.
// Covers the FSM state encoding, slot geometry and fixed AXI attribute values.
package trace_sink_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_AW   = 3'd2,
        ST_W    = 3'd3,
        ST_B    = 3'd4
    } state_t;

    localparam int SLOT_BYTES  = 256;
    localparam int STAGE_BEATS = 4;
    localparam int W_BEATS     = 8;

    localparam logic [1:0] INCR            = 2'b01;
    localparam logic [1:0] OKAY            = 2'b00;
    localparam logic [2:0] AWSIZE_32B      = 3'd5;
    localparam logic [3:0] AWCACHE_DEFAULT = 4'b0011;
    localparam logic [7:0] AWLEN_SLOT      = 8'd7;

endpackage

// File: rtl/trace_sink_stage.sv
// Four-beat 512-bit staging buffer for one ring slot.
// Reads it back as eight 256-bit AXI beats; beats beyond the fill level read as zero data/strobe.
module trace_sink_stage
    import trace_sink_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [511:0] wr_data,
    input  logic [63:0]  wr_keep,
    input  logic         clear,
    input  logic [2:0]   rd_idx,
    output logic [255:0] rd_data,
    output logic [31:0]  rd_strb,
    output logic [2:0]   count
);

    logic [511:0] buf_data [STAGE_BEATS];
    logic [63:0]  buf_keep [STAGE_BEATS];
    logic [1:0]   rd_slot;
    logic         rd_live;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 3'd0;
        end else if (clear) begin
            count <= 3'd0;
        end else if (wr_en && (count < 3'(STAGE_BEATS))) begin
            count <= count + 3'd1;
        end
    end

    // Payload storage needs no reset: the fill count gates what is ever read out.
    always_ff @(posedge clk) begin
        if (wr_en && (count < 3'(STAGE_BEATS))) begin
            buf_data[count[1:0]] <= wr_data;
            buf_keep[count[1:0]] <= wr_keep;
        end
    end

    assign rd_slot = rd_idx[2:1];
    assign rd_live = ({1'b0, rd_slot} < count);

    always_comb begin
        rd_data = '0;
        rd_strb = '0;
        if (rd_live) begin
            if (rd_idx[0]) begin
                rd_data = buf_data[rd_slot][511:256];
                rd_strb = buf_keep[rd_slot][63:32];
            end else begin
                rd_data = buf_data[rd_slot][255:0];
                rd_strb = buf_keep[rd_slot][31:0];
            end
        end
    end

endmodule

// File: rtl/trace_sink.sv
// AXIS trace capture into a DRAM ring of 256-byte slots, one 8x256-bit AXI burst per slot.
// Optional TRACE_SINK_DROP_EN: accept and count (drop_cnt) beats arriving outside FILL instead of backpressuring.
module trace_sink #(
    parameter int ADDR_W     = 36,
    parameter int SLOT_BYTES = trace_sink_pkg::SLOT_BYTES
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s_axis_trace_tvalid,
    output logic              s_axis_trace_tready,
    input  logic [511:0]      s_axis_trace_tdata,
    input  logic [63:0]       s_axis_trace_tkeep,
    input  logic              s_axis_trace_tlast,
    input  logic              cfg_enable,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_size,
    output logic [ADDR_W-1:0] m_axi_mem_awaddr,
    output logic [7:0]        m_axi_mem_awlen,
    output logic [2:0]        m_axi_mem_awsize,
    output logic [1:0]        m_axi_mem_awburst,
    output logic [3:0]        m_axi_mem_awcache,
    output logic              m_axi_mem_awlock,
    output logic [2:0]        m_axi_mem_awprot,
    output logic [3:0]        m_axi_mem_awqos,
    output logic              m_axi_mem_awvalid,
    input  logic              m_axi_mem_awready,
    output logic [255:0]      m_axi_mem_wdata,
    output logic [31:0]       m_axi_mem_wstrb,
    output logic              m_axi_mem_wlast,
    output logic              m_axi_mem_wvalid,
    input  logic              m_axi_mem_wready,
    input  logic [1:0]        m_axi_mem_bresp,
    input  logic              m_axi_mem_bvalid,
    output logic              m_axi_mem_bready,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [31:0]       wrap_cnt,
    output logic              bus_err,
    output logic              busy,
`ifdef TRACE_SINK_DROP_EN
    output logic [31:0]       drop_cnt,
`endif
    output logic [2:0]        dbg_state
);

    import trace_sink_pkg::*;

    // Handshake rule on every channel: a transfer happens on a rising aclk edge where
    // valid and ready are both high; valid never drops and payload never changes before that.

    localparam logic [ADDR_W-1:0] SLOT_INC = ADDR_W'(SLOT_BYTES);

    state_t            state, state_nxt;
    logic [2:0]        w_idx;
    logic [2:0]        stage_cnt;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [ADDR_W-1:0] ptr_next;
    logic              beat_acc;
    logic              slot_done;

    assign beat_acc  = s_axis_trace_tvalid && (state == ST_FILL);
    assign slot_done = (state == ST_B) && m_axi_mem_bvalid;
    assign ptr_next  = wr_ptr + SLOT_INC;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cfg_enable) state_nxt = ST_FILL;
            ST_FILL: begin
                if (beat_acc) begin
                    if (s_axis_trace_tlast || (stage_cnt == 3'(STAGE_BEATS - 1)) || !cfg_enable)
                        state_nxt = ST_AW;
                end else if (!cfg_enable) begin
                    state_nxt = (stage_cnt != 3'd0) ? ST_AW : ST_IDLE;
                end
            end
            ST_AW:   if (m_axi_mem_awready) state_nxt = ST_W;
            ST_W:    if (m_axi_mem_wready && (w_idx == 3'(W_BEATS - 1))) state_nxt = ST_B;
            ST_B:    if (m_axi_mem_bvalid) state_nxt = cfg_enable ? ST_FILL : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= ST_IDLE;
            w_idx     <= 3'd0;
            aw_addr_q <= '0;
            wr_ptr    <= '0;
            wrap_cnt  <= 32'd0;
            bus_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            // Address is frozen when the slot closes so it stays stable while awvalid waits.
            if ((state == ST_FILL) && (state_nxt == ST_AW))
                aw_addr_q <= cfg_base + wr_ptr;
            if ((state == ST_W) && m_axi_mem_wready)
                w_idx <= w_idx + 3'd1;
            if (slot_done) begin
                bus_err <= bus_err | (m_axi_mem_bresp != OKAY);
                // >= rather than == keeps a misprogrammed size from running past the ring.
                if (ptr_next >= cfg_size) begin
                    wr_ptr   <= '0;
                    wrap_cnt <= wrap_cnt + 32'd1;
                end else begin
                    wr_ptr <= ptr_next;
                end
            end
        end
    end

    trace_sink_stage u_stage (
        .clk     (aclk),
        .rst     (areset),
        .wr_en   (beat_acc),
        .wr_data (s_axis_trace_tdata),
        .wr_keep (s_axis_trace_tkeep),
        .clear   (slot_done),
        .rd_idx  (w_idx),
        .rd_data (m_axi_mem_wdata),
        .rd_strb (m_axi_mem_wstrb),
        .count   (stage_cnt)
    );

`ifdef TRACE_SINK_DROP_EN
    assign s_axis_trace_tready = (state == ST_FILL) || (cfg_enable && (state != ST_IDLE));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            drop_cnt <= 32'd0;
        end else if (s_axis_trace_tvalid && s_axis_trace_tready && (state != ST_FILL)
                     && (drop_cnt != 32'hFFFF_FFFF)) begin
            drop_cnt <= drop_cnt + 32'd1;
        end
    end
`else
    assign s_axis_trace_tready = (state == ST_FILL);
`endif

    assign m_axi_mem_awvalid = (state == ST_AW);
    assign m_axi_mem_awaddr  = aw_addr_q;
    assign m_axi_mem_awlen   = AWLEN_SLOT;
    assign m_axi_mem_awsize  = AWSIZE_32B;
    assign m_axi_mem_awburst = INCR;
    assign m_axi_mem_awcache = AWCACHE_DEFAULT;
    assign m_axi_mem_awlock  = 1'b0;
    assign m_axi_mem_awprot  = 3'd0;
    assign m_axi_mem_awqos   = 4'd0;
    assign m_axi_mem_wvalid  = (state == ST_W);
    assign m_axi_mem_wlast   = (state == ST_W) && (w_idx == 3'(W_BEATS - 1));
    assign m_axi_mem_bready  = (state == ST_B);
    assign busy              = (state == ST_AW) || (state == ST_W) || (state == ST_B);
    assign dbg_state         = state;

endmodule
